// File: rtl/kbd_entry_sequencer.sv
// kbd_entry_sequencer
// Turns PS/2 set-2 scancodes into a committed two-digit temperature (0..99),
// a manual smoke toggle, and error pulses for rejected keys or an abandoned
// partial entry. Release codes (F0 xx) and the extended prefix are swallowed.
module kbd_entry_sequencer #(
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    output logic       rx_en,
    output logic [6:0] temp,
    output logic       temp_valid,
    output logic       smoke,
    output logic       err,
    output logic [1:0] digit_cnt
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ONE    = 2'd1,
        TWO    = 2'd2,
        COMMIT = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        K_DIGIT,
        K_ENTER,
        K_BKSP,
        K_H,
        K_BRK,
        K_EXT,
        K_OTHER
    } key_t;

    state_t           state_q, state_d;
    logic             brk_q, brk_d;
    logic [3:0]       d_hi_q, d_hi_d;
    logic [3:0]       d_lo_q, d_lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       temp_q, temp_d;
    logic             temp_valid_q, temp_valid_d;
    logic             smoke_q, smoke_d;
    logic             err_q, err_d;
    logic             rx_en_q, rx_en_d;

    key_t             key;
    logic [3:0]       key_digit;
    logic             accept;
    logic             timeout_hit;
    logic [6:0]       two_digit_val;

    // Classify the incoming scancode into a key kind plus its digit value.
    always_comb begin
        key       = K_OTHER;
        key_digit = 4'd0;
        unique case (rx_data)
            8'h45: begin key = K_DIGIT; key_digit = 4'd0; end
            8'h16: begin key = K_DIGIT; key_digit = 4'd1; end
            8'h1E: begin key = K_DIGIT; key_digit = 4'd2; end
            8'h26: begin key = K_DIGIT; key_digit = 4'd3; end
            8'h25: begin key = K_DIGIT; key_digit = 4'd4; end
            8'h2E: begin key = K_DIGIT; key_digit = 4'd5; end
            8'h36: begin key = K_DIGIT; key_digit = 4'd6; end
            8'h3D: begin key = K_DIGIT; key_digit = 4'd7; end
            8'h3E: begin key = K_DIGIT; key_digit = 4'd8; end
            8'h46: begin key = K_DIGIT; key_digit = 4'd9; end
            8'h5A: key = K_ENTER;
            8'h66: key = K_BKSP;
            8'h33: key = K_H;
            8'hF0: key = K_BRK;
            8'hE0: key = K_EXT;
            default: key = K_OTHER;
        endcase
    end

    // Bytes offered during the commit cycle are dropped; the counter expiry
    // only matters when no byte is being taken in the same cycle.
    assign accept        = rx_done_tick && (state_q != COMMIT);
    assign timeout_hit   = (cnt_q == CNT_LAST);
    // d_hi*10 + d_lo as shifts; the largest result (99) fits in 7 bits.
    assign two_digit_val = ({3'b000, d_hi_q} << 3) + ({3'b000, d_hi_q} << 1)
                         + {3'b000, d_lo_q};

    // Next-state and next-output logic for the entry sequencer.
    always_comb begin
        // NOTE: every signal gets a default here so no path infers a latch.
        state_d      = state_q;
        brk_d        = brk_q;
        d_hi_d       = d_hi_q;
        d_lo_d       = d_lo_q;
        cnt_d        = cnt_q;
        temp_d       = temp_q;
        temp_valid_d = 1'b0;
        smoke_d      = smoke_q;
        err_d        = 1'b0;

        if (state_q == COMMIT) begin
            state_d = IDLE;
            d_hi_d  = 4'd0;
            d_lo_d  = 4'd0;
            cnt_d   = '0;
        end else if (accept) begin
            cnt_d = '0;
            if (brk_q) begin
                // Second byte of a release sequence: consumed, no effect.
                brk_d = 1'b0;
            end else begin
                case (key)
                    K_DIGIT: begin
                        case (state_q)
                            IDLE:    begin d_hi_d = key_digit; state_d = ONE; end
                            ONE:     begin d_lo_d = key_digit; state_d = TWO; end
                            default: err_d = 1'b1;
                        endcase
                    end
                    K_ENTER: begin
                        case (state_q)
                            ONE: begin
                                temp_d       = {3'b000, d_hi_q};
                                temp_valid_d = 1'b1;
                                state_d      = COMMIT;
                            end
                            TWO: begin
                                temp_d       = two_digit_val;
                                temp_valid_d = 1'b1;
                                state_d      = COMMIT;
                            end
                            default: err_d = 1'b1;
                        endcase
                    end
                    K_BKSP: begin
                        case (state_q)
                            TWO:     begin d_lo_d = 4'd0; state_d = ONE;  end
                            ONE:     begin d_hi_d = 4'd0; state_d = IDLE; end
                            default: ;
                        endcase
                    end
                    K_H:     smoke_d = ~smoke_q;
                    K_BRK:   brk_d   = 1'b1;
                    default: ;
                endcase
            end
        end else if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (timeout_hit) begin
            state_d = IDLE;
            d_hi_d  = 4'd0;
            d_lo_d  = 4'd0;
            cnt_d   = '0;
            err_d   = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        rx_en_d = (state_d != COMMIT);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q      <= IDLE;
            brk_q        <= 1'b0;
            d_hi_q       <= 4'd0;
            d_lo_q       <= 4'd0;
            cnt_q        <= '0;
            temp_q       <= 7'd0;
            temp_valid_q <= 1'b0;
            smoke_q      <= 1'b0;
            err_q        <= 1'b0;
            rx_en_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            brk_q        <= brk_d;
            d_hi_q       <= d_hi_d;
            d_lo_q       <= d_lo_d;
            cnt_q        <= cnt_d;
            temp_q       <= temp_d;
            temp_valid_q <= temp_valid_d;
            smoke_q      <= smoke_d;
            err_q        <= err_d;
            rx_en_q      <= rx_en_d;
        end
    end

    // Digit count for the display, derived straight from the registered state.
    always_comb begin
        case (state_q)
            ONE:     digit_cnt = 2'd1;
            TWO:     digit_cnt = 2'd2;
            default: digit_cnt = 2'd0;
        endcase
    end

    assign rx_en      = rx_en_q;
    assign temp       = temp_q;
    assign temp_valid = temp_valid_q;
    assign smoke      = smoke_q;
    assign err        = err_q;

endmodule

// File: tb/tb_kbd_entry_sequencer.sv
// Testbench for kbd_entry_sequencer: directed keyboard scenarios plus random
// scancode traffic, every cycle compared against a queue-based entry model.
module tb_kbd_entry_sequencer;

    localparam int T = 100;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_done_tick;
    logic [7:0] rx_data;
    logic       rx_en;
    logic [6:0] temp;
    logic       temp_valid;
    logic       smoke;
    logic       err;
    logic [1:0] digit_cnt;

    always #5 clk = ~clk;

    kbd_entry_sequencer #(.TIMEOUT_CYC(T)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .rx_en        (rx_en),
        .temp         (temp),
        .temp_valid   (temp_valid),
        .smoke        (smoke),
        .err          (err),
        .digit_cnt    (digit_cnt)
    );

    int    total = 0;
    int    bad   = 0;
    string phase = "init";

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL [%s] %s: got %0d want %0d (t=%0t)", phase, tag, actual, expected, $time);
        end
    endtask

    // ---- reference model: entered digits kept as a plain queue ----
    byte unsigned digit_code [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                      8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    int m_digits [$];
    bit m_brk, m_commit, m_tv, m_smoke, m_err, m_rxen;
    int m_idle, m_temp;

    // counters of observed output activity for the directed scenarios
    int tv_seen, err_seen, rxlow_seen, rxlow_with_tv;

    function automatic int code_to_digit(input logic [7:0] b);
        for (int i = 0; i < 10; i++)
            if (digit_code[i] == b) return i;
        return -1;
    endfunction

    task automatic model_edge(input bit r, input bit t, input logic [7:0] d);
        int v;
        if (r) begin
            m_digits.delete();
            m_brk = 0; m_commit = 0; m_tv = 0; m_smoke = 0; m_err = 0;
            m_rxen = 0; m_idle = 0; m_temp = 0;
            return;
        end
        m_err = 0;
        m_tv  = 0;
        if (m_commit) begin
            m_commit = 0;
            m_idle   = 0;
        end else if (t) begin
            m_idle = 0;
            if (m_brk) m_brk = 0;
            else if (d == 8'hF0) m_brk = 1;
            else if (d == 8'hE0) begin end
            else if (code_to_digit(d) >= 0) begin
                if (m_digits.size() < 2) m_digits.push_back(code_to_digit(d));
                else m_err = 1;
            end else if (d == 8'h5A) begin
                if (m_digits.size() == 0) m_err = 1;
                else begin
                    v = 0;
                    foreach (m_digits[i]) v = v * 10 + m_digits[i];
                    m_temp   = v;
                    m_tv     = 1;
                    m_commit = 1;
                    m_digits.delete();
                end
            end else if (d == 8'h66) begin
                if (m_digits.size() > 0) void'(m_digits.pop_back());
            end else if (d == 8'h33) m_smoke = !m_smoke;
        end else if (m_digits.size() > 0) begin
            if (m_idle == T - 1) begin
                m_digits.delete();
                m_err  = 1;
                m_idle = 0;
            end else m_idle++;
        end
        m_rxen = !m_commit;
    endtask

    // One clock: drive inputs, advance the model at the edge, compare at negedge.
    task automatic step(input bit r, input bit t, input logic [7:0] d);
        reset        = r;
        rx_done_tick = t;
        rx_data      = d;
        @(posedge clk);
        model_edge(r, t, d);
        @(negedge clk);
        check("temp",       temp,       m_temp);
        check("temp_valid", temp_valid, m_tv);
        check("smoke",      smoke,      m_smoke);
        check("err",        err,        m_err);
        check("rx_en",      rx_en,      m_rxen);
        check("digit_cnt",  digit_cnt,  m_commit ? 0 : m_digits.size());
        tv_seen    += int'(temp_valid);
        err_seen   += int'(err);
        rxlow_seen += int'(!rx_en);
        if (!rx_en && temp_valid) rxlow_with_tv++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00);
    endtask

    task automatic send(input logic [7:0] b);
        step(0, 1, b);
        idle(3);
    endtask

    task automatic press(input logic [7:0] b);
        send(b);
        send(8'hF0);
        send(b);
    endtask

    task automatic clear_counts();
        tv_seen = 0; err_seen = 0; rxlow_seen = 0; rxlow_with_tv = 0;
    endtask

    task automatic do_reset();
        step(1, 0, 8'h00);
        step(1, 0, 8'h00);
        step(0, 0, 8'h00);
    endtask

    function automatic logic [7:0] rand_code();
        case ($urandom_range(0, 9))
            0, 1, 2, 3: return digit_code[$urandom_range(0, 9)];
            4:       return 8'h5A;
            5:       return 8'h66;
            6:       return 8'h33;
            7:       return 8'hF0;
            8:       return 8'hE0;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        reset        = 1'b1;
        rx_done_tick = 1'b0;
        rx_data      = 8'h00;

        phase = "reset";
        step(1, 0, 8'h00);
        check("reset_rx_en", rx_en, 0);
        check("reset_temp",  temp,  0);
        step(0, 0, 8'h00);
        check("rx_en_after_reset", rx_en, 1);

        phase = "enter_26";
        clear_counts();
        press(8'h1E); press(8'h36); press(8'h5A);
        check("temp_26",        temp,          26);
        check("tv_pulses",      tv_seen,       1);
        check("err_pulses",     err_seen,      0);
        check("rx_en_low",      rxlow_seen,    1);
        check("rx_en_low_in_commit", rxlow_with_tv, 1);

        phase = "third_digit";
        clear_counts();
        press(8'h46); press(8'h46);
        check("err_before_third", err_seen, 0);
        press(8'h46);
        check("err_on_third", err_seen, 1);
        press(8'h5A);
        check("temp_99",   temp,    99);
        check("tv_pulses", tv_seen, 1);

        phase = "backspace";
        clear_counts();
        press(8'h26); press(8'h66); press(8'h16); press(8'h5A);
        check("temp_1", temp, 1);
        clear_counts();
        press(8'h5A);
        check("enter_idle_err",  err_seen, 1);
        check("enter_idle_temp", temp,     1);
        check("enter_idle_tv",   tv_seen,  0);

        phase = "smoke";
        do_reset();
        check("smoke_init", smoke, 0);
        press(8'h33);
        check("smoke_on", smoke, 1);
        press(8'h33);
        check("smoke_off", smoke, 0);
        press(8'h16);
        check("partial_cnt", digit_cnt, 1);
        press(8'h33);
        check("smoke_partial",     smoke,     1);
        check("partial_cnt_after", digit_cnt, 1);
        press(8'h66);
        check("partial_cleared", digit_cnt, 0);

        phase = "timeout";
        clear_counts();
        step(0, 1, 8'h25);
        idle(T - 1);
        check("no_err_early", err_seen, 0);
        idle(1);
        check("timeout_err", err_seen,  1);
        check("timeout_cnt", digit_cnt, 0);
        idle(2);
        clear_counts();
        send(8'h5A);
        check("enter_after_timeout", err_seen, 1);

        phase = "byte_beats_timeout";
        clear_counts();
        step(0, 1, 8'h16);
        idle(T - 1);
        step(0, 1, 8'h1E);
        idle(3);
        check("collide_err", err_seen,  0);
        check("collide_cnt", digit_cnt, 2);
        send(8'h66); send(8'h66);

        phase = "reset_mid_entry";
        send(8'h16);
        step(1, 0, 8'h00);
        check("rx_en_in_reset", rx_en, 0);
        step(0, 0, 8'h00);
        check("rx_en_after_reset", rx_en,     1);
        check("cnt_after_reset",   digit_cnt, 0);
        clear_counts();
        send(8'h5A);
        check("enter_after_reset_err",  err_seen, 1);
        check("enter_after_reset_temp", temp,     0);

        phase = "random";
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 59) == 0) step(1, 0, 8'h00);
            step(0, 1, rand_code());
            idle($urandom_range(0, 3));
            if ($urandom_range(0, 24) == 0) idle($urandom_range(90, 130));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
